// File: rtl/mmio_ctrl_if.sv
// Core-side MMIO bus and UART handshake signals for mmio_ctrl.
// The br_* signals exist only when MMIO_BRANCH_CTR_EN is defined.
interface mmio_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] io_addr;
    logic [WIDTH-1:0] io_wdata;
    logic             io_re;
    logic             io_we;
    logic [WIDTH-1:0] io_rdata;
    logic             io_stall;
    logic             instr_retire;
    logic [7:0]       uart_rx_data;
    logic             uart_rx_valid;
    logic             uart_rx_ready;
    logic [7:0]       uart_tx_data;
    logic             uart_tx_valid;
    logic             uart_tx_ready;
`ifdef MMIO_BRANCH_CTR_EN
    logic             br_retire;
    logic             br_mispredict;
`endif

    modport slave (
        input  io_addr, io_wdata, io_re, io_we, instr_retire,
        input  uart_rx_data, uart_rx_valid, uart_tx_ready,
`ifdef MMIO_BRANCH_CTR_EN
        input  br_retire, br_mispredict,
`endif
        output io_rdata, io_stall, uart_rx_ready, uart_tx_data, uart_tx_valid
    );

    modport master (
        output io_addr, io_wdata, io_re, io_we, instr_retire,
        output uart_rx_data, uart_rx_valid, uart_tx_ready,
`ifdef MMIO_BRANCH_CTR_EN
        output br_retire, br_mispredict,
`endif
        input  io_rdata, io_stall, uart_rx_ready, uart_tx_data, uart_tx_valid
    );
endinterface

// File: rtl/mmio_ctrl.sv
// MMIO controller for the 0x8xxx_xxxx region: UART status/RX/TX, cycle and instret counters.
// Optional branch counters (0x1C, 0x20) are built when MMIO_BRANCH_CTR_EN is defined.
module mmio_ctrl #(
    parameter int WIDTH = 32,
    parameter int CTR_W = 32
) (
    input logic        clk,
    input logic        rst,
    mmio_ctrl_if.slave bus
);
    typedef enum logic {TX_IDLE, TX_PEND} tx_state_t;

    tx_state_t        tx_state;
    logic [7:0]       tx_data;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] rd_mux;
    logic [CTR_W-1:0] cycle_ctr;
    logic [CTR_W-1:0] instr_ctr;
    logic             io_sel;
    logic [7:0]       off;
    logic             tx_pend;
    logic             wr_tx;
    logic             wr_clr;
    logic             rd_rx;
    logic             unused_bits;

    assign io_sel  = (bus.io_addr[31:30] == 2'b10);
    assign off     = bus.io_addr[7:0];
    assign tx_pend = (tx_state == TX_PEND);
    assign wr_tx   = io_sel & bus.io_we & (off == 8'h08);
    assign wr_clr  = io_sel & bus.io_we & (off == 8'h18);
    assign rd_rx   = io_sel & bus.io_re & (off == 8'h04);

    assign unused_bits = ^{bus.io_addr[WIDTH-1:8], bus.io_wdata[WIDTH-1:8]};

    // Store is held only when the buffer is full and the UART does not drain it this cycle.
    assign bus.io_stall      = wr_tx & tx_pend & ~bus.uart_tx_ready;
    assign bus.uart_rx_ready = rd_rx & bus.uart_rx_valid;
    assign bus.uart_tx_valid = tx_pend;
    assign bus.uart_tx_data  = tx_data;
    assign bus.io_rdata      = rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_data  <= 8'h00;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (wr_tx) begin
                        tx_data  <= bus.io_wdata[7:0];
                        tx_state <= TX_PEND;
                    end
                end
                TX_PEND: begin
                    if (bus.uart_tx_ready) begin
                        if (wr_tx) begin
                            tx_data  <= bus.io_wdata[7:0];
                            tx_state <= TX_PEND;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || wr_clr) begin
            cycle_ctr <= '0;
            instr_ctr <= '0;
        end else begin
            cycle_ctr <= cycle_ctr + 1'b1;
            instr_ctr <= instr_ctr + CTR_W'(bus.instr_retire);
        end
    end

`ifdef MMIO_BRANCH_CTR_EN
    logic [CTR_W-1:0] br_ctr;
    logic [CTR_W-1:0] mispred_ctr;

    always_ff @(posedge clk) begin
        if (rst || wr_clr) begin
            br_ctr      <= '0;
            mispred_ctr <= '0;
        end else begin
            br_ctr      <= br_ctr + CTR_W'(bus.br_retire);
            mispred_ctr <= mispred_ctr + CTR_W'(bus.br_retire & bus.br_mispredict);
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        if (io_sel) begin
            case (off)
                8'h00: rd_mux = WIDTH'({bus.uart_rx_valid, ~tx_pend});
                8'h04: rd_mux = WIDTH'(bus.uart_rx_data);
                8'h10: rd_mux = WIDTH'(cycle_ctr);
                8'h14: rd_mux = WIDTH'(instr_ctr);
`ifdef MMIO_BRANCH_CTR_EN
                8'h1C: rd_mux = WIDTH'(br_ctr);
                8'h20: rd_mux = WIDTH'(mispred_ctr);
`endif
                default: rd_mux = '0;
            endcase
        end
    end

    // Registered read port: same 1-cycle latency as DMEM/BIOS, holds between loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (bus.io_re) begin
            rdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl: reset, UART RX/TX handshakes, stalls, counters, branch counters.
module tb_mmio_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    mmio_ctrl_if #(.WIDTH(32)) bus ();

    mmio_ctrl #(.WIDTH(32), .CTR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.io_re        = 1'b0;
        bus.io_we        = 1'b0;
        bus.instr_retire = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr);
        bus.io_addr = addr;
        bus.io_re   = 1'b1;
        step();
        bus.io_re   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.io_addr       = 32'h0;
        bus.io_wdata      = 32'h0;
        bus.io_re         = 1'b0;
        bus.io_we         = 1'b0;
        bus.instr_retire  = 1'b0;
        bus.uart_rx_data  = 8'h00;
        bus.uart_rx_valid = 1'b0;
        bus.uart_tx_ready = 1'b0;
`ifdef MMIO_BRANCH_CTR_EN
        bus.br_retire     = 1'b0;
        bus.br_mispredict = 1'b0;
`endif
        step(); step(); step();
        check("rst_rdata",    bus.io_rdata, 32'h0);
        check("rst_tx_valid", 32'(bus.uart_tx_valid), 32'h0);
        check("rst_tx_data",  32'(bus.uart_tx_data), 32'h0);
        check("rst_rx_ready", 32'(bus.uart_rx_ready), 32'h0);
        check("rst_stall",    32'(bus.io_stall), 32'h0);
        rst = 1'b0;
        step();

        // Status read with nothing pending
        rd(32'h8000_0000);
        check("status_idle", bus.io_rdata, 32'h0000_0001);

        // RX pop
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'h5A;
        bus.io_addr       = 32'h8000_0004;
        bus.io_re         = 1'b1;
        #1;
        check("rx_ready_pulse", 32'(bus.uart_rx_ready), 32'h1);
        step();
        bus.io_re = 1'b0;
        #1;
        check("rx_ready_drop", 32'(bus.uart_rx_ready), 32'h0);
        check("rx_data", bus.io_rdata, 32'h0000_005A);
        rd(32'h8000_0000);
        check("status_rx", bus.io_rdata, 32'h0000_0003);
        step();
        check("rdata_hold", bus.io_rdata, 32'h0000_0003);

        // RX read with nothing valid: no pop, returns current data
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_data  = 8'h33;
        bus.io_addr       = 32'h8000_0004;
        bus.io_re         = 1'b1;
        #1;
        check("rx_no_pop", 32'(bus.uart_rx_ready), 32'h0);
        step();
        bus.io_re = 1'b0;
        check("rx_data_novalid", bus.io_rdata, 32'h0000_0033);

        // TX back-to-back with UART not ready
        bus.uart_tx_ready = 1'b0;
        bus.io_addr       = 32'h8000_0008;
        bus.io_wdata      = 32'h0000_0041;
        bus.io_we         = 1'b1;
        #1;
        check("tx1_no_stall", 32'(bus.io_stall), 32'h0);
        step();
        check("tx1_valid", 32'(bus.uart_tx_valid), 32'h1);
        check("tx1_data",  32'(bus.uart_tx_data), 32'h41);
        bus.io_wdata = 32'h0000_0042;
        #1;
        check("tx2_stall", 32'(bus.io_stall), 32'h1);
        step();
        check("tx2_stall_hold", 32'(bus.io_stall), 32'h1);
        check("tx2_not_latched", 32'(bus.uart_tx_data), 32'h41);
        bus.uart_tx_ready = 1'b1;
        #1;
        check("tx2_stall_release", 32'(bus.io_stall), 32'h0);
        step();
        bus.io_we         = 1'b0;
        bus.uart_tx_ready = 1'b0;
        #1;
        check("tx2_data",  32'(bus.uart_tx_data), 32'h42);
        check("tx2_valid", 32'(bus.uart_tx_valid), 32'h1);
        rd(32'h8000_0000);
        check("status_tx_busy", bus.io_rdata, 32'h0000_0000);

        // Stall only for IO stores to 0x08
        bus.io_we   = 1'b1;
        bus.io_addr = 32'h8000_000C;
        #1;
        check("stall_other_off", 32'(bus.io_stall), 32'h0);
        bus.io_addr = 32'h0000_0008;
        #1;
        check("stall_non_io", 32'(bus.io_stall), 32'h0);
        bus.io_we   = 1'b0;
        bus.uart_tx_ready = 1'b1;
        step();
        bus.uart_tx_ready = 1'b0;
        check("tx_drained", 32'(bus.uart_tx_valid), 32'h0);
        rd(32'h8000_0000);
        check("status_tx_free", bus.io_rdata, 32'h0000_0001);

        // Counter clear wins over retire
        bus.io_addr      = 32'h8000_0018;
        bus.io_we        = 1'b1;
        bus.instr_retire = 1'b1;
        step();
        idle_bus();
        rd(32'h8000_0014);
        check("instr_after_clr", bus.io_rdata, 32'h0);
        rd(32'h8000_0010);
        check("cycle_after_clr", bus.io_rdata, 32'h1);

        // 100 cycles, 40 retires
        bus.io_addr = 32'h8000_0018;
        bus.io_we   = 1'b1;
        step();
        bus.io_we   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.instr_retire = ((i % 5) < 2);
            step();
        end
        bus.instr_retire = 1'b0;
        rd(32'h8000_0010);
        check("cycle_100", bus.io_rdata, 32'd100);
        rd(32'h8000_0014);
        check("instr_40", bus.io_rdata, 32'd40);

        // Branch counters
        bus.io_addr = 32'h8000_0018;
        bus.io_we   = 1'b1;
        step();
        bus.io_we   = 1'b0;
`ifdef MMIO_BRANCH_CTR_EN
        for (int i = 0; i < 7; i++) begin
            bus.br_retire     = (i != 3) && (i != 5);
            bus.br_mispredict = (i == 1) || (i == 4) || (i == 5);
            step();
        end
        bus.br_retire     = 1'b0;
        bus.br_mispredict = 1'b0;
        rd(32'h8000_001C);
        check("br_ctr", bus.io_rdata, 32'd5);
        rd(32'h8000_0020);
        check("mispred_ctr", bus.io_rdata, 32'd2);
`else
        rd(32'h8000_001C);
        check("br_ctr_absent", bus.io_rdata, 32'h0);
        rd(32'h8000_0020);
        check("mispred_absent", bus.io_rdata, 32'h0);
`endif

        // Reset mid-transfer drops the pending byte
        bus.io_addr  = 32'h8000_0008;
        bus.io_wdata = 32'h0000_0055;
        bus.io_we    = 1'b1;
        step();
        bus.io_we    = 1'b0;
        check("tx3_valid", 32'(bus.uart_tx_valid), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_valid", 32'(bus.uart_tx_valid), 32'h0);
        check("rst_mid_data",  32'(bus.uart_tx_data), 32'h0);
        rd(32'h8000_0014);
        check("rst_mid_instr", bus.io_rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
